// File: rtl/sd_sector_buffer.sv
// sd_sector_buffer: receive-side stage between the SD card controller and the CPU bus.
// A cmd_start pulse launches one sector read. The block presents the sector address and
// a read request to the controller, then captures each delivered byte into a sector
// buffer that the bus reads back by byte offset.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   cmd_start, cmd_sector start pulse and sector address from the bus write decode
//   sd_rd, sd_address     registered read request / sector address to the controller
//   sd_ready              controller idle/ready
//   sd_byte_available     level, high while sd_dout holds a valid byte
//   sd_dout               controller byte output
//   bus_rd_en/addr        bus read strobe and byte offset
//   bus_rd_data/valid     registered buffer byte and its one-cycle valid pulse
//   busy, done, error     transfer status (done/error sticky until the next start)
//   byte_count            bytes captured in the current or last transfer
module sd_sector_buffer #(
  parameter int unsigned SECTOR_BYTES = 512,
  parameter int unsigned AW           = 9,
  parameter int unsigned TIMEOUT      = 50_000_000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_start,
  input  logic [31:0]   cmd_sector,
  output logic          sd_rd,
  output logic [31:0]   sd_address,
  input  logic          sd_ready,
  input  logic          sd_byte_available,
  input  logic [7:0]    sd_dout,
  input  logic          bus_rd_en,
  input  logic [AW-1:0] bus_rd_addr,
  output logic [7:0]    bus_rd_data,
  output logic          bus_rd_valid,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW:0]   byte_count
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   Full    = (AW + 1)'(SECTOR_BYTES);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StWaitRdy, StIssue, StRecv, StDrain} state_e;

  state_e        state;
  logic [TW-1:0] tmo_cnt;
  logic          avail_s;   // synchronising flop for sd_byte_available
  logic          avail_d;   // delayed copy for rising-edge detection
  logic          capture;
  logic [7:0]    mem [SECTOR_BYTES];

  // sd_dout is sampled in the edge-detect cycle; bytes past a full sector are dropped.
  assign capture = (state == StRecv) && avail_s && !avail_d && (byte_count < Full);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      tmo_cnt    <= '0;
      avail_s    <= 1'b0;
      avail_d    <= 1'b0;
      sd_rd      <= 1'b0;
      sd_address <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      byte_count <= '0;
    end else begin
      avail_s <= sd_byte_available;
      avail_d <= avail_s;
      tmo_cnt <= tmo_cnt + 1'b1;
      unique case (state)
        StIdle: begin
          tmo_cnt <= '0;
          if (cmd_start) begin
            sd_address <= cmd_sector;
            done       <= 1'b0;
            error      <= 1'b0;
            byte_count <= '0;
            busy       <= 1'b1;
            state      <= StWaitRdy;
          end
        end
        StWaitRdy: begin
          if (sd_ready) begin
            sd_rd   <= 1'b1;
            tmo_cnt <= '0;
            state   <= StIssue;
          end
        end
        StIssue: begin
          // Controller drops ready once it has accepted the request.
          if (!sd_ready) begin
            sd_rd   <= 1'b0;
            tmo_cnt <= '0;
            state   <= StRecv;
          end
        end
        StRecv: begin
          if (capture) begin
            byte_count <= byte_count + 1'b1;
            tmo_cnt    <= '0;
            if (byte_count == Full - 1'b1) state <= StDrain;
          end
        end
        StDrain: begin
          // Ready returns after the CRC bytes, which are not stored.
          if (sd_ready) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            tmo_cnt <= '0;
            state   <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
      // Timeout overrides any pending transition; byte_count keeps its partial value.
      if (state != StIdle && tmo_cnt == TmoLast) begin
        sd_rd   <= 1'b0;
        busy    <= 1'b0;
        error   <= 1'b1;
        tmo_cnt <= '0;
        state   <= StIdle;
      end
    end
  end

  // Buffer write port, kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (capture) mem[byte_count[AW-1:0]] <= sd_dout;
  end

  // Registered read port: a same-cycle write to the same offset yields the old byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_rd_data  <= '0;
      bus_rd_valid <= 1'b0;
    end else begin
      bus_rd_valid <= bus_rd_en;
      if (bus_rd_en) bus_rd_data <= mem[bus_rd_addr];
    end
  end

endmodule

// File: tb/tb_sd_sector_buffer.sv
// Testbench for sd_sector_buffer: controller model driving sector transfers, a byte-level
// reference image of the buffer, and a scoreboard checking every bus read response.
module tb_sd_sector_buffer;

  localparam int AW = 9;
  localparam int SB = 512;
  localparam int TMO = 100;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_start;
  logic [31:0]   cmd_sector;
  logic          sd_rd;
  logic [31:0]   sd_address;
  logic          sd_ready;
  logic          sd_byte_available;
  logic [7:0]    sd_dout;
  logic          bus_rd_en;
  logic [AW-1:0] bus_rd_addr;
  logic [7:0]    bus_rd_data;
  logic          bus_rd_valid;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   byte_count;

  sd_sector_buffer #(
    .SECTOR_BYTES(SB),
    .AW          (AW),
    .TIMEOUT     (TMO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_start        (cmd_start),
    .cmd_sector       (cmd_sector),
    .sd_rd            (sd_rd),
    .sd_address       (sd_address),
    .sd_ready         (sd_ready),
    .sd_byte_available(sd_byte_available),
    .sd_dout          (sd_dout),
    .bus_rd_en        (bus_rd_en),
    .bus_rd_addr      (bus_rd_addr),
    .bus_rd_data      (bus_rd_data),
    .bus_rd_valid     (bus_rd_valid),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .byte_count       (byte_count)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         rd_rises = 0;
  logic       rd_prev = 1'b0;
  logic [7:0] model_mem [SB];   // expected buffer image
  logic [7:0] tx [SB + 2];      // bytes the controller model sends this transfer
  logic [7:0] exp_q [$];        // expected bus read responses, in order

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (sd_rd && !rd_prev) rd_rises++;
    rd_prev = sd_rd;
  end

  // Scoreboard monitor: every valid response must match the oldest outstanding read.
  initial forever begin
    logic [7:0] e;
    @(negedge clk);
    if (!reset && bus_rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_data: got %0h with no read outstanding", bus_rd_data);
      end else begin
        e = exp_q.pop_front();
        if (bus_rd_data !== e) begin
          errors++;
          $display("FAIL rd_data: got %0h expected %0h", bus_rd_data, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic fill_random();
    for (int k = 0; k < SB + 2; k++) tx[k] = 8'($urandom);
  endtask

  task automatic bus_read(input int a);
    @(posedge clk); #1;
    bus_rd_en = 1'b1;
    bus_rd_addr = AW'(a);
    exp_q.push_back(model_mem[a]);
    @(posedge clk); #1;
    bus_rd_en = 1'b0;
    check("rd_valid_next_cycle", bus_rd_valid, 1);
    @(posedge clk); #1;
    check("rd_valid_pulse", bus_rd_valid, 0);
  endtask

  task automatic bus_burst(input int n, input int lo, input int hi);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus_rd_en = 1'b1;
      bus_rd_addr = AW'($urandom_range(hi, lo));
      exp_q.push_back(model_mem[bus_rd_addr]);
    end
    @(posedge clk); #1;
    bus_rd_en = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // One sector transfer as seen from the controller. Negative *_at arguments disable
  // the corresponding event (rejected start, collision read, reset, stall).
  task automatic run_xfer(input logic [31:0] sector, input int nbytes, input int reject_at,
                          input int collide_at, input int reset_at, input int stall_at);
    int rise_cyc;
    int n_hi;
    rise_cyc = 0;
    @(posedge clk); #1;
    cmd_start = 1'b1;
    cmd_sector = sector;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    cmd_sector = $urandom;
    @(negedge clk);
    check("busy_at_1", busy, 1);
    check("done_cleared", done, 0);
    check("error_cleared", error, 0);
    check("count_cleared", byte_count, 0);
    check("rd_low_at_1", sd_rd, 0);
    @(negedge clk);
    check("rd_at_2", sd_rd, 1);
    check("address", sd_address, sector);
    n_hi = 0;
    repeat (3) begin
      @(negedge clk);
      if (sd_rd) n_hi++;
    end
    check("rd_held_while_ready", n_hi, 3);
    @(posedge clk); #1;
    sd_ready = 1'b0;
    @(negedge clk);
    check("rd_until_ready_sampled", sd_rd, 1);
    @(negedge clk);
    check("rd_drop", sd_rd, 0);

    for (int k = 0; k < nbytes; k++) begin
      if (k == stall_at) break;
      @(posedge clk); #1;
      sd_byte_available = 1'b1;
      sd_dout = tx[k];
      rise_cyc = cyc;
      if (k == reset_at) begin
        #2 reset = 1'b1;
        #1 check("reset_outputs_mid",
                 {sd_rd, sd_address, bus_rd_data, bus_rd_valid, busy, done, error, byte_count},
                 0);
        check("reset_rd_low", sd_rd, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sd_byte_available = 1'b0;
        sd_ready = 1'b1;
        return;
      end
      for (int c = 0; c < 4; c++) begin
        if (k == reject_at && c == 0) begin
          cmd_start = 1'b1;
          cmd_sector = 32'h20;
        end
        if (k == reject_at && c == 1) cmd_start = 1'b0;
        // Strobe offset 5 exactly in its write cycle, then once more right after.
        if (k == collide_at && c == 1) begin
          bus_rd_en = 1'b1;
          bus_rd_addr = AW'(5);
          exp_q.push_back(model_mem[5]);
        end
        if (k == collide_at && c == 2) exp_q.push_back(tx[k]);
        if (k == collide_at && c == 3) bus_rd_en = 1'b0;
        @(posedge clk); #1;
      end
      sd_byte_available = 1'b0;
      sd_dout = 8'($urandom);
      if (k < SB) model_mem[k] = tx[k];
    end

    if (stall_at >= 0) begin
      while (cyc < rise_cyc + TMO + 1) @(negedge clk);
      check("no_error_before_timeout", error, 0);
      @(negedge clk);
      check("error_at_timeout", error, 1);
      check("busy_after_timeout", busy, 0);
      check("rd_after_timeout", sd_rd, 0);
      check("count_after_timeout", byte_count, stall_at);
      check("done_after_timeout", done, 0);
      sd_ready = 1'b1;
      return;
    end

    repeat (2) @(posedge clk);
    #1 sd_ready = 1'b1;
    @(negedge clk);
    check("done_not_early", done, 0);
    @(negedge clk);
    check("done", done, 1);
    check("busy_end", busy, 0);
    check("count_end", byte_count, (nbytes < SB) ? nbytes : SB);
    check("error_end", error, 0);
    check("address_end", sd_address, sector);
    check("rd_end", sd_rd, 0);
  endtask

  initial begin
    reset = 1'b1;
    cmd_start = 1'b0;
    cmd_sector = '0;
    sd_ready = 1'b1;
    sd_byte_available = 1'b0;
    sd_dout = '0;
    bus_rd_en = 1'b0;
    bus_rd_addr = '0;
    for (int k = 0; k < SB; k++) model_mem[k] = '0;
    #12;
    check("reset_outputs_init",
          {sd_rd, sd_address, bus_rd_data, bus_rd_valid, busy, done, error, byte_count}, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Full sector of 0x00..0xFF repeated, with a start pulse for sector 0x20 mid-receive.
    for (int k = 0; k < SB + 2; k++) tx[k] = 8'(k);
    run_xfer(32'h10, SB, 100, -1, -1, -1);
    check("single_rd_pulse", rd_rises, 1);
    bus_read(0);
    bus_read(9'h0FF);
    bus_read(9'h1FF);
    bus_burst(8, 0, SB - 1);

    // Random sector that leaves 0x3C at offset 5.
    fill_random();
    tx[5] = 8'h3C;
    run_xfer($urandom, SB, -1, -1, -1, -1);
    bus_burst(8, 0, SB - 1);

    // Collision on offset 5 plus two overrun bytes that must not wrap.
    fill_random();
    tx[5] = 8'hA5;
    run_xfer($urandom, SB + 2, -1, 5, -1, -1);
    bus_read(0);
    bus_burst(8, 0, SB - 1);

    // Reset at byte 200, then a clean transfer.
    fill_random();
    run_xfer($urandom, SB, -1, -1, 200, -1);
    fill_random();
    run_xfer($urandom, SB, -1, -1, -1, -1);
    bus_burst(16, 0, SB - 1);

    // Controller stalls after 37 bytes; the tail of the buffer keeps stale bytes.
    fill_random();
    run_xfer($urandom, SB, -1, -1, -1, 37);
    bus_burst(8, 0, 36);
    bus_burst(8, 37, SB - 1);

    // Next start must clear error and run to completion.
    fill_random();
    run_xfer($urandom, SB, -1, -1, -1, -1);
    bus_burst(8, 0, SB - 1);

    repeat (4) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
